// File: rtl/lc3_writeback.sv
// LC3 writeback stage: result select, 8-entry register file, NZP condition codes.
// Optional macro LC3_WB_WRITE_THROUGH_EN forwards the in-flight write value to the read ports.
module lc3_writeback #(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8,
   localparam int AW     = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_writeback,
   input  logic [1:0]        W_control,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] pcout,
   input  logic [DATA_W-1:0] memout,
   input  logic [AW-1:0]     dr,
   input  logic [AW-1:0]     sr1,
   input  logic [AW-1:0]     sr2,
   output logic [DATA_W-1:0] VSR1,
   output logic [DATA_W-1:0] VSR2,
   output logic [2:0]        psr,
   output logic              wb_valid,
   output logic [AW-1:0]     wb_dr,
   output logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] rf [REG_CNT];
   logic [DATA_W-1:0] wr_val;
   logic              wr_en;
   logic [2:0]        cc_next;

   // W_control is only meaningful when enable_writeback is high; && keeps an X select harmless.
   assign wr_en = enable_writeback && (W_control != 2'b11);

   always_comb begin
      wr_val = pcout;
      case (W_control)
         2'b00:   wr_val = aluout;
         2'b01:   wr_val = memout;
         default: wr_val = pcout;
      endcase
   end

   always_comb begin
      cc_next = 3'b001;
      if (wr_val[DATA_W-1])
         cc_next = 3'b100;
      else if (wr_val == '0)
         cc_next = 3'b010;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_CNT; i++)
            rf[i] <= '0;
         psr      <= 3'b010;
         wb_valid <= 1'b0;
         wb_dr    <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= wr_en;
         if (wr_en) begin
            rf[dr]  <= wr_val;
            psr     <= cc_next;
            wb_dr   <= dr;
            wb_data <= wr_val;
         end
      end
   end

`ifdef LC3_WB_WRITE_THROUGH_EN
   assign VSR1 = (wr_en && (sr1 == dr)) ? wr_val : rf[sr1];
   assign VSR2 = (wr_en && (sr2 == dr)) ? wr_val : rf[sr2];
`else
   // Read-before-write; execute-stage bypass paths cover the same-cycle hazard.
   assign VSR1 = rf[sr1];
   assign VSR2 = rf[sr2];
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed scenarios plus randomized traffic
// against a register-array reference model.
module tb_lc3_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable_writeback;
   logic [1:0]  W_control;
   logic [15:0] aluout, pcout, memout;
   logic [2:0]  dr, sr1, sr2;
   logic [15:0] VSR1, VSR2;
   logic [2:0]  psr;
   logic        wb_valid;
   logic [2:0]  wb_dr;
   logic [15:0] wb_data;

   int errors = 0;
   int checks = 0;

   logic [15:0] m_rf [8];
   logic [2:0]  m_psr;
   logic        m_valid;
   logic [2:0]  m_dr;
   logic [15:0] m_data;

   lc3_writeback dut (
      .clk(clk), .reset(reset), .enable_writeback(enable_writeback), .W_control(W_control),
      .aluout(aluout), .pcout(pcout), .memout(memout), .dr(dr), .sr1(sr1), .sr2(sr2),
      .VSR1(VSR1), .VSR2(VSR2), .psr(psr), .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   function automatic logic m_wen();
      return enable_writeback && (W_control != 2'b11);
   endfunction

   function automatic logic [15:0] m_val();
      if (W_control == 2'b00) return aluout;
      if (W_control == 2'b01) return memout;
      return pcout;
   endfunction

   function automatic logic [2:0] m_cc(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 16'h0000) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [15:0] exp_rd(input logic [2:0] s);
`ifdef LC3_WB_WRITE_THROUGH_EN
      if (m_wen() && s == dr) return m_val();
`endif
      return m_rf[s];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_psr = 3'b010; m_valid = 1'b0; m_dr = 3'd0; m_data = 16'h0000;
   endtask

   task automatic drive(input logic en, input logic [1:0] wc, input logic [15:0] a,
                        input logic [15:0] p, input logic [15:0] m, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2);
      @(negedge clk);
      enable_writeback = en; W_control = wc; aluout = a; pcout = p; memout = m;
      dr = d; sr1 = s1; sr2 = s2;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_wen()) begin
         m_rf[dr] = m_val(); m_psr = m_cc(m_val());
         m_valid = 1'b1; m_dr = dr; m_data = m_val();
      end else begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
      model_reset();
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i); #1;
         checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL reset_vsr1[%0d] got %h exp 0000", i, VSR1); end
         checks++; if (VSR2 !== 16'h0000) begin errors++; $display("FAIL reset_vsr2[%0d] got %h exp 0000", 7 - i, VSR2); end
      end
      checks++; if (psr !== 3'b010) begin errors++; $display("FAIL reset_psr got %b exp 010", psr); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      checks++; if (wb_dr !== 3'd0 || wb_data !== 16'h0) begin
         errors++; $display("FAIL reset_wb got dr=%0d data=%h exp 0/0000", wb_dr, wb_data); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_alu_negative();
      drive(1'b1, 2'b00, 16'h8001, 16'h1111, 16'h2222, 3'd3, 3'd0, 3'd0);
      tick();
      drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 3'd3, 3'd0);
      checks++; if (VSR1 !== 16'h8001) begin errors++; $display("FAIL alu_vsr1 got %h exp 8001", VSR1); end
      checks++; if (psr !== 3'b100) begin errors++; $display("FAIL alu_psr got %b exp 100", psr); end
      checks++; if (wb_valid !== 1'b1 || wb_dr !== 3'd3 || wb_data !== 16'h8001) begin
         errors++; $display("FAIL alu_wb got v=%b dr=%0d data=%h exp 1/3/8001", wb_valid, wb_dr, wb_data); end
      tick();
   endtask

   task automatic test_mem_pc();
      drive(1'b1, 2'b01, 16'h7777, 16'h5555, 16'h0000, 3'd5, 3'd0, 3'd0);
      tick();
      checks++; if (psr !== 3'b010) begin errors++; $display("FAIL mem_zero_psr got %b exp 010", psr); end
      drive(1'b1, 2'b10, 16'h7777, 16'h3005, 16'h4444, 3'd6, 3'd0, 3'd0);
      tick();
      checks++; if (psr !== 3'b001) begin errors++; $display("FAIL pc_pos_psr got %b exp 001", psr); end
      drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 3'd5, 3'd6);
      checks++; if (VSR1 !== 16'h0000) begin errors++; $display("FAIL mem_vsr1 got %h exp 0000", VSR1); end
      checks++; if (VSR2 !== 16'h3005) begin errors++; $display("FAIL pc_vsr2 got %h exp 3005", VSR2); end
      tick();
   endtask

   task automatic test_no_write();
      drive(1'b1, 2'b00, 16'h1234, 16'h0, 16'h0, 3'd2, 3'd0, 3'd0);
      tick();
      drive(1'b1, 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd2, 3'd2, 3'd2);
      tick();
      checks++; if (VSR1 !== 16'h1234) begin errors++; $display("FAIL nowrite_vsr1 got %h exp 1234", VSR1); end
      checks++; if (psr !== 3'b001) begin errors++; $display("FAIL nowrite_psr got %b exp 001", psr); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nowrite_wb_valid got %b exp 0", wb_valid); end
   endtask

   task automatic test_same_cycle();
      logic [15:0] exp_now;
`ifdef LC3_WB_WRITE_THROUGH_EN
      exp_now = 16'h00AA;
`else
      exp_now = 16'h0007;
`endif
      drive(1'b1, 2'b00, 16'h0007, 16'h0, 16'h0, 3'd4, 3'd0, 3'd0);
      tick();
      drive(1'b1, 2'b00, 16'h00AA, 16'h0, 16'h0, 3'd4, 3'd4, 3'd4);
      checks++; if (VSR1 !== exp_now) begin errors++; $display("FAIL rw_same_vsr1 got %h exp %h", VSR1, exp_now); end
      checks++; if (VSR2 !== exp_now) begin errors++; $display("FAIL rw_same_vsr2 got %h exp %h", VSR2, exp_now); end
      tick();
      drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 3'd4, 3'd4);
      checks++; if (VSR1 !== 16'h00AA || VSR2 !== 16'h00AA) begin
         errors++; $display("FAIL rw_next got %h/%h exp 00aa/00aa", VSR1, VSR2); end
      tick();
   endtask

   task automatic test_disabled();
      logic [2:0]  psr0, dr0;
      logic [15:0] data0;
      logic [15:0] rf0 [8];
      drive(1'b1, 2'b10, 16'h0, 16'hC0DE, 16'h0, 3'd1, 3'd0, 3'd0);
      tick();
      psr0 = m_psr; dr0 = m_dr; data0 = m_data;
      for (int i = 0; i < 8; i++) rf0[i] = m_rf[i];
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 2'(c), 16'($urandom), 16'($urandom), 16'($urandom), 3'(c + 1), 3'(c), 3'(c + 1));
         tick();
         checks++; if (psr !== psr0) begin errors++; $display("FAIL dis_psr[%0d] got %b exp %b", c, psr, psr0); end
         checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL dis_valid[%0d] got %b exp 0", c, wb_valid); end
         checks++; if (wb_dr !== dr0 || wb_data !== data0) begin
            errors++; $display("FAIL dis_wb_hold[%0d] got %0d/%h exp %0d/%h", c, wb_dr, wb_data, dr0, data0); end
         checks++; if (VSR1 !== rf0[c] || VSR2 !== rf0[c + 1]) begin
            errors++; $display("FAIL dis_rf[%0d] got %h/%h exp %h/%h", c, VSR1, VSR2, rf0[c], rf0[c + 1]); end
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'b00, 16'h0011, 16'h0, 16'h0, 3'd7, 3'd0, 3'd0); tick();
      drive(1'b1, 2'b01, 16'h0, 16'h0, 16'h9000, 3'd7, 3'd0, 3'd0); tick();
      drive(1'b1, 2'b10, 16'h0, 16'h0022, 16'h0, 3'd7, 3'd7, 3'd7); tick();
      checks++; if (VSR1 !== 16'h0022 || psr !== 3'b001) begin
         errors++; $display("FAIL b2b got %h psr %b exp 0022 psr 001", VSR1, psr); end
   endtask

   task automatic test_random();
      logic [15:0] v;
      for (int n = 0; n < 300; n++) begin
         v = 16'($urandom);
         if (n % 7 == 0) v = 16'h0000;
         drive($urandom_range(0, 3) != 0, 2'($urandom), v, 16'($urandom) | 16'h8000,
               16'($urandom) & 16'h7FFF, 3'($urandom), 3'($urandom), 3'($urandom));
         checks++; if (VSR1 !== exp_rd(sr1)) begin
            errors++; $display("FAIL rnd_vsr1[%0d] got %h exp %h", n, VSR1, exp_rd(sr1)); end
         checks++; if (VSR2 !== exp_rd(sr2)) begin
            errors++; $display("FAIL rnd_vsr2[%0d] got %h exp %h", n, VSR2, exp_rd(sr2)); end
         tick();
         checks++; if (psr !== m_psr || wb_valid !== m_valid || wb_dr !== m_dr || wb_data !== m_data) begin
            errors++; $display("FAIL rnd_regs[%0d] got psr=%b v=%b dr=%0d d=%h exp psr=%b v=%b dr=%0d d=%h",
                               n, psr, wb_valid, wb_dr, wb_data, m_psr, m_valid, m_dr, m_data); end
      end
   endtask

   task automatic test_midsim_reset();
      drive(1'b1, 2'b00, 16'hBEEF, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0); tick();
      drive(1'b1, 2'b00, 16'h1357, 16'h0, 16'h0, 3'd6, 3'd0, 3'd6);
      #2 reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(i); #1;
         checks++; if (VSR1 !== 16'h0000 || VSR2 !== 16'h0000) begin
            errors++; $display("FAIL midrst_rf[%0d] got %h/%h exp 0000", i, VSR1, VSR2); end
      end
      checks++; if (psr !== 3'b010 || wb_valid !== 1'b0 || wb_dr !== 3'd0 || wb_data !== 16'h0) begin
         errors++; $display("FAIL midrst_regs got psr=%b v=%b dr=%0d d=%h exp 010/0/0/0000", psr, wb_valid, wb_dr, wb_data); end
      @(negedge clk); reset = 1'b1;
      tick();
      checks++; if (psr !== 3'b001 || wb_valid !== 1'b1 || wb_dr !== 3'd6) begin
         errors++; $display("FAIL post_rst_write got psr=%b v=%b dr=%0d exp 001/1/6", psr, wb_valid, wb_dr); end
   endtask

   initial begin
      test_reset();
      test_alu_negative();
      test_mem_pc();
      test_no_write();
      test_same_cycle();
      test_disabled();
      test_back_to_back();
      test_random();
      test_midsim_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
